hazard_control: RTL and testbench

- Produces the stall, flush and forwarding controls that drive the pipeline registers, including the decode→execute register's stall_e/flush_e inputs.
- Sits beside the five-stage MIPS datapath and observes register addresses and control bits from the D, E, M and W stages.
- Contains a small FSM and counter that hold the pipeline while a multi-cycle mul/div operation occupies execute.
- All hazard and forwarding outputs are combinational from the inputs and the FSM state.

---
 rtl/hazard_control.sv | 109 ++++++++++
 tb/tb_hazard_control.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_control.sv
// Hazard unit for the five-stage MIPS pipeline: stall/flush/forward controls
// plus a small FSM that holds E while a multi-cycle mul/div occupies it.
module hazard_control #(
    parameter int REG_BITS   = 5,
    parameter int MD_LATENCY = 4,
    parameter int CNT_BITS   = 4
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [REG_BITS-1:0] rs_d,
    input  logic [REG_BITS-1:0] rt_d,
    input  logic [REG_BITS-1:0] rs_e,
    input  logic [REG_BITS-1:0] rt_e,
    input  logic [REG_BITS-1:0] write_reg_e,
    input  logic [REG_BITS-1:0] write_reg_m,
    input  logic [REG_BITS-1:0] write_reg_w,
    input  logic                reg_write_e,
    input  logic                reg_write_m,
    input  logic                reg_write_w,
    input  logic                mem_to_reg_e,
    input  logic                mem_to_reg_m,
    input  logic                branch_d,
    input  logic                pc_src_d,
    input  logic                jump_d,
    input  logic                md_start_e,
    output logic                stall_f,
    output logic                stall_d,
    output logic                stall_e,
    output logic                flush_d,
    output logic                flush_e,
    output logic                forward_a_d,
    output logic                forward_b_d,
    output logic [1:0]          forward_a_e,
    output logic [1:0]          forward_b_e,
    output logic                md_busy,
    output logic                md_done
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(MD_LATENCY - 2);
    localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

    state_t              r_state;
    logic [CNT_BITS-1:0] r_cnt;

    logic w_lw_stall;
    logic w_br_stall;
    logic w_md_stall;
    logic w_stall;

    // Register 0 is hardwired, so it never creates a dependency.
    function automatic logic hit(input logic [REG_BITS-1:0] a, input logic [REG_BITS-1:0] b);
        return (a != '0) && (a == b);
    endfunction

    always_comb begin
        forward_a_e = 2'b00;
        forward_b_e = 2'b00;
        if (reg_write_m && hit(write_reg_m, rs_e))      forward_a_e = 2'b10;
        else if (reg_write_w && hit(write_reg_w, rs_e)) forward_a_e = 2'b01;
        if (reg_write_m && hit(write_reg_m, rt_e))      forward_b_e = 2'b10;
        else if (reg_write_w && hit(write_reg_w, rt_e)) forward_b_e = 2'b01;
    end

    assign forward_a_d = reg_write_m && hit(write_reg_m, rs_d);
    assign forward_b_d = reg_write_m && hit(write_reg_m, rt_d);

    assign w_lw_stall = mem_to_reg_e && (hit(write_reg_e, rs_d) || hit(write_reg_e, rt_d));
    assign w_br_stall = branch_d &&
        ((reg_write_e  && (hit(write_reg_e, rs_d) || hit(write_reg_e, rt_d))) ||
         (mem_to_reg_m && (hit(write_reg_m, rs_d) || hit(write_reg_m, rt_d))));
    assign w_md_stall = ((r_state == IDLE) && md_start_e) || (r_state == BUSY);
    assign w_stall    = w_lw_stall || w_br_stall || w_md_stall;

    assign stall_f = w_stall;
    assign stall_d = w_stall;
    assign stall_e = w_md_stall;
    // A held E stage must keep its instruction, so it is never flushed.
    assign flush_e = (w_lw_stall || w_br_stall) && !w_md_stall;
    assign flush_d = (pc_src_d || jump_d) && !w_stall;

    assign md_busy = (r_state == BUSY);
    assign md_done = (r_state == DONE);

    // DONE ignores md_start_e: the finishing instruction is still in E.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: if (md_start_e) begin
                    if (MD_LATENCY == 2) begin
                        r_state <= DONE;
                    end else begin
                        r_state <= BUSY;
                        r_cnt   <= CNT_LOAD;
                    end
                end
                BUSY: if (r_cnt == CNT_ONE) r_state <= DONE;
                      else                  r_cnt   <= r_cnt - CNT_ONE;
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_control.sv
// Scoreboard bench for hazard_control: directed scenarios then random traffic,
// checked against an occupancy-age model of the mul/div unit.
module tb_hazard_control;

    localparam int L  = 4;
    localparam int RB = 5;
    localparam int W  = 13;

    typedef struct packed {
        logic          clr;
        logic [RB-1:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
        logic          rw_e, rw_m, rw_w, m2r_e, m2r_m, br_d, pc_d, j_d, md;
    } in_t;

    logic clk = 1'b0;
    in_t  din;

    logic stall_f, stall_d, stall_e, flush_d, flush_e, forward_a_d, forward_b_d;
    logic [1:0] forward_a_e, forward_b_e;
    logic md_busy, md_done;

    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    int checks = 0;
    int errors = 0;

    // age of the mul/div in E: 0 = none, 1..L = cycle of its occupancy
    int   m_age = 0;
    int   m_eff = 0;
    logic m_prev_clr = 1'b1;

    always #5 clk = ~clk;

    hazard_control #(.REG_BITS(RB), .MD_LATENCY(L), .CNT_BITS(4)) dut (
        .clk(clk), .clr(din.clr),
        .rs_d(din.rs_d), .rt_d(din.rt_d), .rs_e(din.rs_e), .rt_e(din.rt_e),
        .write_reg_e(din.wr_e), .write_reg_m(din.wr_m), .write_reg_w(din.wr_w),
        .reg_write_e(din.rw_e), .reg_write_m(din.rw_m), .reg_write_w(din.rw_w),
        .mem_to_reg_e(din.m2r_e), .mem_to_reg_m(din.m2r_m),
        .branch_d(din.br_d), .pc_src_d(din.pc_d), .jump_d(din.j_d), .md_start_e(din.md),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
        .flush_d(flush_d), .flush_e(flush_e),
        .forward_a_d(forward_a_d), .forward_b_d(forward_b_d),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .md_busy(md_busy), .md_done(md_done)
    );

    function automatic logic dep(input logic [RB-1:0] a, input logic [RB-1:0] b);
        return (a != 0) && (a == b);
    endfunction

    function automatic logic [1:0] fwd_sel(input in_t v, input logic [RB-1:0] src);
        if (v.rw_m && dep(v.wr_m, src)) return 2'd2;
        if (v.rw_w && dep(v.wr_w, src)) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [W-1:0] model(input in_t v, input int eff);
        logic lw, br, md, st;
        lw = v.m2r_e && (dep(v.wr_e, v.rs_d) || dep(v.wr_e, v.rt_d));
        br = v.br_d && ((v.rw_e && (dep(v.wr_e, v.rs_d) || dep(v.wr_e, v.rt_d))) ||
                        (v.m2r_m && (dep(v.wr_m, v.rs_d) || dep(v.wr_m, v.rt_d))));
        md = (eff >= 1) && (eff <= L - 1);
        st = lw || br || md;
        return {st, st, md, (v.pc_d || v.j_d) && !st, (lw || br) && !md,
                v.rw_m && dep(v.wr_m, v.rs_d), v.rw_m && dep(v.wr_m, v.rt_d),
                fwd_sel(v, v.rs_e), fwd_sel(v, v.rt_e),
                (eff >= 2) && (eff <= L - 1), eff == L};
    endfunction

    // Applies one cycle of inputs just after the edge and queues the expected outputs.
    task automatic drive(input in_t v, input string tag);
        @(posedge clk);
        #1;
        if (v.clr || m_prev_clr)   m_age = 0;
        else if (m_eff == 0)       m_age = 0;
        else if (m_eff < L)        m_age = m_eff + 1;
        else                       m_age = 0;
        m_eff      = (m_age == 0 && v.md) ? 1 : m_age;
        m_prev_clr = v.clr;
        din = v;
        exp_q.push_back(model(v, m_eff));
        tag_q.push_back(tag);
    endtask

    always @(negedge clk) begin
        logic [W-1:0] act, exp_v;
        string        tg;
        if (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            tg    = tag_q.pop_front();
            act = {stall_f, stall_d, stall_e, flush_d, flush_e, forward_a_d, forward_b_d,
                   forward_a_e, forward_b_e, md_busy, md_done};
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL %s: got %b expected %b (sf sd se fd fe fad fbd fae fbe busy done)",
                         tg, act, exp_v);
            end
        end
    end

    initial begin
        in_t v;
        din = '0;
        din.clr = 1'b1;
        v = '0; v.clr = 1'b1;
        drive(v, "reset");
        drive(v, "reset_hold");
        v.clr = 1'b0;
        drive(v, "idle_zero");

        // forwarding priority M over W
        v = '0; v.rw_m = 1; v.wr_m = 8; v.rw_w = 1; v.wr_w = 8; v.rs_e = 8;
        drive(v, "fwd_m_prio");
        v.wr_m = 9;
        drive(v, "fwd_w");
        v.rs_e = 0; v.wr_w = 0; v.rt_e = 9;
        drive(v, "fwd_b_m");

        // load-use, then register 0
        v = '0; v.m2r_e = 1; v.rw_e = 1; v.wr_e = 5; v.rt_d = 5;
        drive(v, "load_use");
        v.wr_e = 0; v.rt_d = 0;
        drive(v, "load_use_r0");

        // branch dependent on E, then resolved
        v = '0; v.br_d = 1; v.rs_d = 3; v.rw_e = 1; v.wr_e = 3; v.pc_d = 1;
        drive(v, "branch_stall");
        v.wr_e = 7;
        drive(v, "branch_flush");
        v = '0; v.br_d = 1; v.rt_d = 6; v.m2r_m = 1; v.rw_m = 1; v.wr_m = 6;
        drive(v, "branch_load_m");

        // mul/div held start: L-1 stall cycles, DONE, then restart
        v = '0; v.md = 1;
        for (int i = 0; i < L + 2; i++) drive(v, "md_seq");

        // asynchronous clear mid-BUSY, then stay idle
        v = '0; v.clr = 1;
        drive(v, "md_clr");
        v.clr = 0;
        drive(v, "md_after_clr");
        drive(v, "md_after_clr2");

        // load-use while busy
        v = '0; v.md = 1;
        drive(v, "md_start");
        v.m2r_e = 1; v.rw_e = 1; v.wr_e = 5; v.rt_d = 5;
        drive(v, "md_busy_load_use");
        v = '0; v.md = 1; v.j_d = 1;
        drive(v, "md_busy_jump");
        v = '0; v.j_d = 1;
        drive(v, "md_done_jump");

        // random traffic on a small register range to provoke matches
        for (int i = 0; i < 400; i++) begin
            v = '0;
            v.clr   = ($urandom_range(0, 39) == 0);
            v.rs_d  = RB'($urandom_range(0, 3)); v.rt_d = RB'($urandom_range(0, 3));
            v.rs_e  = RB'($urandom_range(0, 3)); v.rt_e = RB'($urandom_range(0, 3));
            v.wr_e  = RB'($urandom_range(0, 3)); v.wr_m = RB'($urandom_range(0, 3));
            v.wr_w  = RB'($urandom_range(0, 3));
            v.rw_e  = 1'($urandom); v.rw_m = 1'($urandom); v.rw_w = 1'($urandom);
            v.m2r_e = 1'($urandom); v.m2r_m = 1'($urandom);
            v.br_d  = 1'($urandom); v.pc_d = 1'($urandom); v.j_d = 1'($urandom);
            v.md    = ($urandom_range(0, 3) == 0);
            drive(v, "random");
        end

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
